// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with fill level, almost-full/empty flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle reads.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 12,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  ERR_CLR
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_L = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_L = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                af_q, af_d;
    logic                ae_q, ae_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                wr_en, rd_en;

    // Accept decisions use only the registered flags, so a full/empty FIFO
    // never accepts on the strength of a simultaneous opposite operation.
    assign wr_en = W_INC && !full_q;
    assign rd_en = R_INC && !empty_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

        // Pointer difference modulo 2*DEPTH yields 0..DEPTH directly.
        level_d = wr_ptr_d - rd_ptr_d;
        full_d  = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                  (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        af_d    = (level_d >= AF_L);
        ae_d    = (level_d <= AE_L);

        ovf_d = ovf_q;
        if (W_INC && full_q)   ovf_d = 1'b1;
        else if (ERR_CLR)      ovf_d = 1'b0;

        unf_d = unf_q;
        if (R_INC && empty_q)  unf_d = 1'b1;
        else if (ERR_CLR)      unf_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; stale words are unreachable
    // once the pointers are cleared, and a plain RAM can then be inferred.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= WR_DATA;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign RD_DATA  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign RD_VALID = !empty_q;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
`endif

    assign FULL         = full_q;
    assign ALMOST_FULL  = af_q;
    assign EMPTY        = empty_q;
    assign ALMOST_EMPTY = ae_q;
    assign LEVEL        = level_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule
